// File: rtl/adsr_env.sv
// ADSR envelope generator: one-pole filter toward a per-phase target, updated on tick.
// Define ADSR_RETRIG_EN to restart ATTACK from zero on a gate rising edge during RELEASE.
module adsr_env #(
  parameter int TAU_BITS = 16,
  parameter int ENV_BITS = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                gate,
  input  logic [TAU_BITS-1:0] attack_tau,
  input  logic [TAU_BITS-1:0] decay_tau,
  input  logic [TAU_BITS-1:0] release_tau,
  input  logic [ENV_BITS-1:0] peak,
  input  logic [ENV_BITS-1:0] sustain_lvl,
  output logic [ENV_BITS-1:0] envelope,
  output logic [2:0]          state,
  output logic                busy,
  output logic                done
);

  // state   | meaning
  // IDLE    | envelope held at 0, waiting for gate
  // ATTACK  | rising toward peak at attack_tau
  // DECAY   | moving toward sustain_lvl at decay_tau
  // SUSTAIN | tracking sustain_lvl at decay_tau while gate held
  // RELEASE | falling toward 0 at release_tau
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ATTACK  = 3'd1;
  localparam logic [2:0] DECAY   = 3'd2;
  localparam logic [2:0] SUSTAIN = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;

  localparam int DW = ENV_BITS + 1;
  localparam int PW = ENV_BITS + TAU_BITS + 2;

  logic [2:0]                state_q, state_d, eff_state;
  logic [ENV_BITS-1:0]       env_d, env_upd, target;
  logic [TAU_BITS-1:0]       tau;
  logic                      gate_q, gate_rise, done_d, zero_env, allow_tick;
  logic signed [DW-1:0]      diff, product, step;
  logic signed [TAU_BITS:0]  tau_s;
  logic signed [PW-1:0]      prod_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      envelope <= '0;
      gate_q   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      envelope <= env_d;
      gate_q   <= gate;
      done     <= done_d;
    end
  end

  always_comb begin
    gate_rise  = gate & ~gate_q;
    eff_state  = state_q;
    zero_env   = 1'b0;
    allow_tick = tick;
    // Gate-driven moves are resolved first; a same-cycle tick uses the resulting phase.
    case (state_q)
      IDLE:                    eff_state = gate ? ATTACK : IDLE;
      ATTACK, DECAY, SUSTAIN:  if (!gate) eff_state = RELEASE;
      RELEASE: begin
        if (gate_rise) begin
          eff_state = ATTACK;
`ifdef ADSR_RETRIG_EN
          zero_env   = 1'b1;
          allow_tick = 1'b0;
`endif
        end
      end
      default:                 eff_state = IDLE;
    endcase

    case (eff_state)
      ATTACK:          begin target = peak;        tau = attack_tau;  end
      DECAY, SUSTAIN:  begin target = sustain_lvl; tau = decay_tau;   end
      RELEASE:         begin target = '0;          tau = release_tau; end
      default:         begin target = '0;          tau = '0;          end
    endcase

    diff      = $signed({1'b0, target}) - $signed({1'b0, envelope});
    tau_s     = $signed({1'b0, tau});
    prod_full = PW'(diff) * PW'(tau_s);
    product   = DW'(prod_full >>> TAU_BITS);
    // A zero product with a nonzero error would stall; force a unit step so the target is always hit.
    if (product == '0 && diff != '0)
      step = diff[DW-1] ? '1 : DW'(1);
    else
      step = product;
    env_upd = ENV_BITS'($unsigned(step) + {1'b0, envelope});

    state_d = eff_state;
    env_d   = envelope;
    done_d  = 1'b0;
    if (eff_state == IDLE) begin
      env_d = '0;
    end else if (zero_env) begin
      env_d = '0;
    end else if (allow_tick) begin
      env_d = env_upd;
      case (eff_state)
        ATTACK:  if (env_upd == peak)        state_d = DECAY;
        DECAY:   if (env_upd == sustain_lvl) state_d = SUSTAIN;
        RELEASE: if (env_upd == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state = state_q;
    busy  = (state_q != IDLE);
  end

endmodule

// File: doc/adsr_env.md
ADSR_ENV -- requirements
Module: adsr_env

Interface
REQ-001 The block SHALL have parameter TAU_BITS, default 16, meaning width of each unsigned Q0.TAU_BITS rate coefficient.
REQ-002 The block SHALL have parameter ENV_BITS, default 24, meaning width of the unsigned envelope and level inputs.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port tick, input, 1 bit: sample strobe; the envelope updates only in cycles with tick=1.
REQ-006 The block SHALL have port gate, input, 1 bit: note held (level).
REQ-007 The block SHALL have ports attack_tau, decay_tau and release_tau, input, TAU_BITS each: per-phase rate coefficients.
REQ-008 The block SHALL have port peak, input, ENV_BITS: attack target level.
REQ-009 The block SHALL have port sustain_lvl, input, ENV_BITS: decay and sustain target level.
REQ-010 The block SHALL have port envelope, output, ENV_BITS: registered envelope value.
REQ-011 The block SHALL have port state, output, 3 bits, encoded IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
REQ-012 The block SHALL have port busy, output, 1 bit: state != IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse on the RELEASE->IDLE transition.

Function
REQ-014 The block SHALL register gate, as gate_q, to detect a rising edge (gate & ~gate_q).
REQ-015 Per state, target/tau SHALL be: ATTACK peak/attack_tau; DECAY and SUSTAIN sustain_lvl/decay_tau; RELEASE 0/release_tau; IDLE holds envelope=0.
REQ-016 On tick in a non-IDLE state, diff SHALL be computed as the (ENV_BITS+1)-bit signed value target - envelope, and product as the arithmetic right shift (floor) of diff*tau by TAU_BITS.
REQ-017 If product=0 and diff!=0, the step SHALL be +1 or -1 (sign of diff); otherwise the step SHALL be product, giving guaranteed exact convergence (tau=0 gives a unit-step linear ramp).
REQ-018 The block SHALL set envelope <= envelope + step; the result never leaves [0, 2^ENV_BITS-1] because the step never overshoots the target.
REQ-019 Latency: envelope SHALL reflect a tick exactly one clock after the tick cycle; inputs are sampled live at each tick, not latched.
REQ-020 IDLE SHALL go to ATTACK when gate=1.
REQ-021 ATTACK, DECAY and SUSTAIN SHALL go to RELEASE when gate=0, regardless of tick.
REQ-022 RELEASE SHALL go to ATTACK on a gate rising edge (start level per REQ-031/REQ-032).
REQ-023 When gate stays high, ATTACK SHALL go to DECAY on the tick whose updated envelope equals peak, and DECAY SHALL go to SUSTAIN on the tick whose updated envelope equals sustain_lvl.
REQ-024 SUSTAIN SHALL keep filtering toward sustain_lvl, so a sustain_lvl change glides at decay_tau.
REQ-025 RELEASE SHALL go to IDLE, with done=1 for one cycle, on the tick whose updated envelope equals 0.
REQ-026 Simultaneous events: gate-driven transitions SHALL be evaluated first; a tick in the same cycle then SHALL use the new state's target/tau; level-reached transitions use the updated value.
REQ-027 The block SHALL handle these boundaries: peak=0 means ATTACK->DECAY on its first tick; sustain_lvl >= peak means DECAY rises to sustain_lvl; gate=0 while in IDLE means no action.
REQ-028 Unused state encodings SHALL return to IDLE with envelope=0 on the next clock.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, envelope=0, gate_q=0, done=0 and busy=0, including mid-phase.
REQ-030 After rst_n deasserts, a held-high gate SHALL be seen as a rising edge, starting ATTACK on the first clock.

Configuration
REQ-031 With macro ADSR_RETRIG_EN defined, a gate rising edge in RELEASE SHALL zero envelope in that cycle and enter ATTACK from 0; any same-cycle tick is discarded.
REQ-032 Without ADSR_RETRIG_EN, the same event SHALL enter ATTACK from the current envelope (legato), and a same-cycle tick SHALL apply attack_tau per REQ-026.

Verification
REQ-033 The bench SHALL check: reset, then gate=1, peak=0x00F000, attack_tau=0x8000, tick every cycle -> envelope 0x007800, 0x00B400, ... reaches exactly 0x00F000, then state=DECAY.
REQ-034 The bench SHALL check: sustain_lvl=0x004000, decay_tau=0x4000 after DECAY entry -> monotonic fall to exactly 0x004000, then state=SUSTAIN; a later sustain_lvl=0x006000 glides up and state stays SUSTAIN.
REQ-035 The bench SHALL check: gate=0 in SUSTAIN with release_tau=0 -> state=RELEASE next clock, envelope drops by 1 per tick, done pulses once at 0, busy=0.
REQ-036 The bench SHALL check: gate 0->1 in RELEASE at envelope=0x001000 -> ATTACK from 0x001000 without the macro, or from 0 with ADSR_RETRIG_EN.
REQ-037 The bench SHALL check: tick held 0 for 100 cycles in ATTACK -> envelope constant; a tick coinciding with gate fall -> one release_tau step applied.
REQ-038 The bench SHALL check: rst_n pulsed low mid-ATTACK without a clock edge -> envelope=0 and state=0 asynchronously.
